batch_uart_sender: RTL and testbench
====================================

// Module: batch_uart_sender
// PURPOSE
//  Downstream stage of the bit-to-byte collector. After a batch of BATCH_SIZE
//  bytes has been written to the shared batch RAM, this block reads it back
//  from address 0 upward and serialises each byte on a UART line (8N1, LSB
//  first) for off-board capture. It is one-shot per start edge and reports done.
// PARAMETERS
//  BATCH_SIZE      1000                  bytes per batch; addresses 0..BATCH_SIZE-1
//  MEM_ADDR_WIDTH  $clog2(BATCH_SIZE)    RAM address width
//  CLKS_PER_BIT    868                   clk cycles per UART bit (100 MHz/115200); must be >= 2
// PORTS
//  clk       in   1               clock, all logic on rising edge
//  rst       in   1               reset, synchronous, active-high
//  start     in   1               level input; a 0->1 edge (registered internally) starts a batch
//  mem_oe    out  1               RAM read enable, one-cycle pulse per byte
//  mem_addr  out  MEM_ADDR_WIDTH  RAM read address
//  mem_dout  in   8               RAM read data, valid the cycle after mem_oe=1
//  tx        out  1               UART serial output, idle high
//  busy      out  1               high while a batch is in progress
//  done      out  1               sticky batch-complete flag
// BEHAVIOUR
//  - Reset values: tx=1, mem_oe=0, mem_addr=0, busy=0, done=0, byte index=0, state=IDLE.
//    rst overrides everything. Mid-frame reset returns tx high on the next edge; no partial frame resumes.
//  - Start edge: start_r <= start each cycle; edge = start & ~start_r. The edge is acted on only in IDLE.
//    It is ignored while busy. Holding start high yields exactly one batch.
//  - On an accepted edge: done<=0, busy<=1, idx<=0, state->REQ.
//  - FSM: IDLE -> REQ -> WAIT -> START -> DATA -> STOP -> (REQ | FINISH) -> IDLE
//    REQ   : 1 cycle; mem_oe=1, mem_addr=idx.
//    WAIT  : 1 cycle; mem_oe=0. At the end of this cycle, shift_reg <= mem_dout.
//    START : tx=0 for CLKS_PER_BIT cycles.
//    DATA  : 8 bits, shift_reg[0] first, each held CLKS_PER_BIT cycles.
//            3-bit bit counter; baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
//    STOP  : tx=1 for CLKS_PER_BIT cycles. Then, if idx==BATCH_SIZE-1, go to FINISH;
//            otherwise idx<=idx+1 and go to REQ.
//    FINISH: 1 cycle; done<=1, busy<=0, then IDLE.
//  - tx is registered and is 1 in every state except START and DATA.
//  - Byte period = 10*CLKS_PER_BIT + 2 cycles. The 2 cycles are REQ and WAIT, with tx high.
//  - Latency: the start edge is seen in cycle 0, REQ is cycle 1, and the first tx=0 is driven in cycle 3.
//  - mem_addr never exceeds BATCH_SIZE-1. idx does not wrap within a batch.
//  - done stays 1 until rst or the next accepted start edge. busy and done are never both 1.
//  - An edge arriving in the FINISH cycle is ignored; the source must toggle start again.
// STRUCTURE
//  - Shared package batch_pkg holds the FSM state localparams, the default CLKS_PER_BIT and BATCH_SIZE,
//    and the UART frame constants (START=0, STOP=1, DATA_BITS=8).
//  - Sub-module uart_tx_8n1 (ports: clk, rst, tx_start, tx_data[7:0], tx, tx_busy) owns
//    START/DATA/STOP and the baud counter. The top keeps IDLE/REQ/WAIT/FINISH, idx and the start edge.
//    The cycle timing above must still hold exactly.
// TESTING (BATCH_SIZE=4, CLKS_PER_BIT=4, 1-cycle-latency RAM model preloaded A5,00,FF,3C)
//  1. Start edge at cycle 0 -> mem_oe at cycle 1 (addr 0); tx frame 0,1,0,1,0,0,1,0,1,1 (4 cyc each)
//     from cycle 3; all 4 bytes in order; done=1 and busy=0 at cycle 1+4*42.
//  2. start held high for the whole run -> exactly one batch; mem_oe pulses 4 times, addresses 0,1,2,3.
//  3. Second start edge during byte 2 -> ignored; addresses and tx identical to scenario 1.
//  4. rst asserted mid-DATA of byte 1 -> next edge tx=1, busy=0, done=0, mem_oe=0;
//     a new edge restarts from addr 0.
//  5. After done, toggle start -> done clears on the accepted edge; batch repeats bit-exact.
//  6. Bit-timing check on byte 0x00 and byte 0xFF -> each bit exactly 4 cycles;
//     2 idle-high cycles between stop bit and next start bit.

Source files
------------

// File: rtl/batch_pkg.sv
// Shared definitions for the batch UART sender: default sizing, 8N1 frame
// constants and the state encodings of the sequencer and the serialiser.
package batch_pkg;

  localparam int DEFAULT_BATCH_SIZE   = 1000;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_FINISH
  } senderState_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uartState_e;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serialiser, LSB first, with a registered line output. Each frame is
// exactly 10*CLKS_PER_BIT cycles long.
module uart_tx_8n1
  import batch_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uartState_e        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shiftReg_q, shiftReg_d;
  logic              tx_q, tx_d;
  logic              lastTick;

  assign lastTick = (baud_q == LAST_TICK);
  assign tx       = tx_q;
  // Drops in the final stop-bit cycle so the caller can request the next
  // byte without losing a cycle between frames.
  assign tx_busy  = (state_q != U_IDLE) && !((state_q == U_STOP) && lastTick);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= U_IDLE;
      baud_q     <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      tx_q       <= STOP_BIT;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    tx_d       = tx_q;
    unique case (state_q)
      U_IDLE: begin
        tx_d = STOP_BIT;
        if (tx_start) begin
          shiftReg_d = tx_data;
          tx_d       = START_BIT;
          baud_d     = '0;
          state_d    = U_START;
        end
      end
      U_START: begin
        if (lastTick) begin
          baud_d   = '0;
          bitIdx_d = '0;
          tx_d     = shiftReg_q[0];
          state_d  = U_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      U_DATA: begin
        if (lastTick) begin
          baud_d = '0;
          if (bitIdx_q == LAST_BIT) begin
            tx_d    = STOP_BIT;
            state_d = U_STOP;
          end else begin
            bitIdx_d   = bitIdx_q + 1'b1;
            shiftReg_d = {1'b0, shiftReg_q[7:1]};
            tx_d       = shiftReg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      U_STOP: begin
        if (lastTick) begin
          baud_d  = '0;
          state_d = U_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

endmodule

// File: rtl/batch_uart_sender.sv
// Reads a batch of bytes from the shared RAM starting at address 0 and sends
// each one over UART; one batch per rising edge of start, then flags done.
module batch_uart_sender
  import batch_pkg::*;
#(
  parameter int BATCH_SIZE     = DEFAULT_BATCH_SIZE,
  parameter int MEM_ADDR_WIDTH = $clog2(BATCH_SIZE),
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      mem_oe,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]                mem_dout,
  output logic                      tx,
  output logic                      busy,
  output logic                      done
);

  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_IDX = MEM_ADDR_WIDTH'(BATCH_SIZE - 1);

  senderState_e              state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      start_q;
  logic                      startEdge;
  logic                      txStart;
  logic                      txBusy;

  assign startEdge = start & ~start_q;
  assign mem_addr  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start;
    end
  end

  // done/busy flip on entry to FINISH so they are already visible during it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mem_oe  = 1'b0;
    txStart = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (startEdge) begin
          done_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_oe  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        txStart = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!txBusy) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clk     (clk),
    .rst     (rst),
    .tx_start(txStart),
    .tx_data (mem_dout),
    .tx      (tx),
    .tx_busy (txBusy)
  );

endmodule

// File: tb/tb_batch_uart_sender.sv
// Directed bench for batch_uart_sender with a 4-byte batch, 4 clocks per bit
// and a one-cycle-latency RAM preloaded with A5,00,FF,3C.
module tb_batch_uart_sender;

  localparam int NCYC = 172;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mem_oe;
  logic [1:0] mem_addr;
  logic [7:0] mem_dout;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] ram [4];
  logic       txLog [NCYC];
  int         checkCount;
  int         passCount;

  batch_uart_sender #(
    .BATCH_SIZE  (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mem_oe  (mem_oe),
    .mem_addr(mem_addr),
    .mem_dout(mem_dout),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_oe) mem_dout <= ram[mem_addr];
  end

  // Cycle c counts from the cycle in which the start edge is first visible.
  function automatic logic expTx(input int c);
    int off;
    logic [7:0] v;
    if (c < 1 || c > 168) return 1'b1;
    off = (c - 1) % 42;
    v = ram[(c - 1) / 42];
    if (off < 2) return 1'b1;
    if (off < 6) return 1'b0;
    if (off < 38) return v[(off - 6) / 4];
    return 1'b1;
  endfunction

  function automatic logic expOe(input int c);
    return (c >= 1 && c <= 168 && ((c - 1) % 42) == 0);
  endfunction

  function automatic int runLen(input int from, input logic val);
    int n;
    n = 0;
    for (int i = from; i < NCYC; i++) begin
      if (txLog[i] !== val) break;
      n++;
    end
    return n;
  endfunction

  // mode 0: single pulse on start; 1: start held high; 2: extra edge during byte 2.
  task automatic runBatch(input string name, input int mode);
    int txBad, oeBad, addrBad, busyBad, doneBad, oeCount;
    logic txG, txE, oeG, oeE, busyG, busyE, doneG, doneE;
    logic [1:0] addrG, addrE;
    logic eBusy, eDone;
    txBad = -1; oeBad = -1; addrBad = -1; busyBad = -1; doneBad = -1; oeCount = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (c == 0) start = 1'b1;
      eBusy = (c >= 1 && c <= 168);
      eDone = (c >= 169);
      if (tx !== expTx(c) && txBad < 0) begin
        txBad = c; txG = tx; txE = expTx(c);
      end
      if (mem_oe !== expOe(c) && oeBad < 0) begin
        oeBad = c; oeG = mem_oe; oeE = expOe(c);
      end
      if (expOe(c) && mem_addr !== 2'((c - 1) / 42) && addrBad < 0) begin
        addrBad = c; addrG = mem_addr; addrE = 2'((c - 1) / 42);
      end
      if (busy !== eBusy && busyBad < 0) begin
        busyBad = c; busyG = busy; busyE = eBusy;
      end
      if (c >= 1 && done !== eDone && doneBad < 0) begin
        doneBad = c; doneG = done; doneE = eDone;
      end
      if (mem_oe === 1'b1) oeCount++;
      txLog[c] = tx;
      if (mode != 1 && c == 1) start = 1'b0;
      if (mode == 2 && c == 90) start = 1'b1;
      if (mode == 2 && c == 94) start = 1'b0;
      @(negedge clk);
    end
    checkCount++;
    if (txBad >= 0) $display("[TB] FAIL %s.tx cycle %0d got %b expected %b", name, txBad, txG, txE);
    else passCount++;
    checkCount++;
    if (oeBad >= 0) $display("[TB] FAIL %s.mem_oe cycle %0d got %b expected %b", name, oeBad, oeG, oeE);
    else passCount++;
    checkCount++;
    if (addrBad >= 0) $display("[TB] FAIL %s.mem_addr cycle %0d got %0d expected %0d", name, addrBad, addrG, addrE);
    else passCount++;
    checkCount++;
    if (busyBad >= 0) $display("[TB] FAIL %s.busy cycle %0d got %b expected %b", name, busyBad, busyG, busyE);
    else passCount++;
    checkCount++;
    if (doneBad >= 0) $display("[TB] FAIL %s.done cycle %0d got %b expected %b", name, doneBad, doneG, doneE);
    else passCount++;
    checkCount++;
    if (oeCount !== 4) $display("[TB] FAIL %s.oeCount got %0d expected 4", name, oeCount);
    else passCount++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if (tx !== 1'b1) $display("[TB] FAIL reset.tx got %b expected 1", tx); else passCount++;
    checkCount++;
    if (mem_oe !== 1'b0) $display("[TB] FAIL reset.mem_oe got %b expected 0", mem_oe); else passCount++;
    checkCount++;
    if (mem_addr !== 2'd0) $display("[TB] FAIL reset.mem_addr got %0d expected 0", mem_addr); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset.busy got %b expected 0", busy); else passCount++;
    checkCount++;
    if (done !== 1'b0) $display("[TB] FAIL reset.done got %b expected 0", done); else passCount++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_start();
    int extraOe, extraBusy, lowDone;
    runBatch("hold", 1);
    extraOe = 0; extraBusy = 0; lowDone = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_oe !== 1'b0) extraOe++;
      if (busy !== 1'b0) extraBusy++;
      if (done !== 1'b1) lowDone++;
      @(negedge clk);
    end
    checkCount++;
    if (extraOe != 0) $display("[TB] FAIL hold.extraOe got %0d expected 0", extraOe); else passCount++;
    checkCount++;
    if (extraBusy != 0) $display("[TB] FAIL hold.extraBusy got %0d expected 0", extraBusy); else passCount++;
    checkCount++;
    if (lowDone != 0) $display("[TB] FAIL hold.doneSticky got %0d low cycles expected 0", lowDone); else passCount++;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_restart_after_done();
    checkCount++;
    if (done !== 1'b1) $display("[TB] FAIL restart.doneBefore got %b expected 1", done); else passCount++;
    runBatch("restart", 0);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 1) start = 1'b0;
      @(negedge clk);
    end
    checkCount++;
    if (tx !== 1'b0) $display("[TB] FAIL midReset.txBefore got %b expected 0", tx); else passCount++;
    rst = 1'b1;
    @(negedge clk);
    checkCount++;
    if (tx !== 1'b1) $display("[TB] FAIL midReset.tx got %b expected 1", tx); else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL midReset.busy got %b expected 0", busy); else passCount++;
    checkCount++;
    if (done !== 1'b0) $display("[TB] FAIL midReset.done got %b expected 0", done); else passCount++;
    checkCount++;
    if (mem_oe !== 1'b0) $display("[TB] FAIL midReset.mem_oe got %b expected 0", mem_oe); else passCount++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    runBatch("afterReset", 0);
  endtask

  task automatic test_bit_timing();
    runBatch("timing", 0);
    checkCount++;
    if (txLog[44] !== 1'b1 || txLog[45] !== 1'b0)
      $display("[TB] FAIL timing.byte1StartEdge got %b%b expected 10", txLog[44], txLog[45]);
    else passCount++;
    checkCount++;
    if (runLen(45, 1'b0) != 36) $display("[TB] FAIL timing.zeroByteLow got %0d expected 36", runLen(45, 1'b0));
    else passCount++;
    checkCount++;
    if (runLen(81, 1'b1) != 6) $display("[TB] FAIL timing.stopPlusGap got %0d expected 6", runLen(81, 1'b1));
    else passCount++;
    checkCount++;
    if (runLen(87, 1'b0) != 4) $display("[TB] FAIL timing.startBit got %0d expected 4", runLen(87, 1'b0));
    else passCount++;
    checkCount++;
    if (runLen(91, 1'b1) != 38) $display("[TB] FAIL timing.ffByteHigh got %0d expected 38", runLen(91, 1'b1));
    else passCount++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    ram[0] = 8'hA5;
    ram[1] = 8'h00;
    ram[2] = 8'hFF;
    ram[3] = 8'h3C;
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    test_reset();
    runBatch("basic", 0);
    repeat (3) @(negedge clk);
    test_restart_after_done();
    repeat (3) @(negedge clk);
    runBatch("ignoreEdge", 2);
    repeat (3) @(negedge clk);
    test_hold_start();
    test_mid_reset();
    repeat (3) @(negedge clk);
    test_bit_timing();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
